seq_serializer: RTL

Parallel-to-serial front end for the bit-sequence detectors. Accepts DW-bit words over a valid/ready handshake and emits them one bit per clock on o_seq, with a configurable bit order. A one-word holding register lets consecutive words stream with no idle gap. o_seq drives the detector's serial input (i_seq) directly.

---
 rtl/seq_pkg.sv | 18 +
 rtl/seq_skid_reg.sv | 37 +++
 rtl/seq_serializer.sv | 108 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence front end and its detectors:
// FSM state encodings and a width helper for bit counters.
package seq_pkg;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_skid_reg.sv
// One-entry valid/ready holding buffer. Write side: wr_valid/wr_ready;
// read side: rd_valid/rd_ready. A transfer occurs on a rising edge when both
// valid and ready are high on that side.
module seq_skid_reg #(
    parameter int W = 9
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic [W-1:0] wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    input  logic         rd_ready
);

    logic [W-1:0] data_q;
    logic         full_q;

    // Write is only possible while empty, so write and drain never collide.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (wr_valid && !full_q) begin
            data_q <= wr_data;
            full_q <= 1'b1;
        end else if (rd_ready && full_q) begin
            full_q <= 1'b0;
        end
    end

    assign wr_ready = !full_q;
    assign rd_valid = full_q;
    assign rd_data  = data_q;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: takes DW-bit words over valid/ready and emits
// one bit per clock on o_seq, MSB- or LSB-first per word, with zero-gap streaming.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    input  logic          i_msb_first,
    output logic          o_ready,
    output logic          o_seq,
    output logic          o_seq_vld,
    output logic          o_busy,
    output logic [0:0]    o_state
);

    localparam int            CW   = clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic [0:0]    state_q, state_d;
    logic [DW-1:0] sr_q, sr_d;
    logic          msb_q, msb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          accept;
    logic          last_bit;
    logic          hold_wr;
    logic          hold_full;
    logic [DW:0]   hold_word;

    assign accept   = i_valid && o_ready;
    assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST);
    // Mid-word accepts park in hold; an accept on the last-bit edge goes straight to sr.
    assign hold_wr  = accept && (state_q == S_SHIFT) && !last_bit;

    seq_skid_reg #(
        .W(DW + 1)
    ) u_hold (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .wr_data  ({i_msb_first, i_data}),
        .wr_valid (hold_wr),
        .wr_ready (o_ready),
        .rd_data  (hold_word),
        .rd_valid (hold_full),
        .rd_ready (last_bit)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        msb_d   = msb_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sr_d    = i_data;
                    msb_d   = i_msb_first;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!last_bit) begin
                    sr_d  = msb_q ? {sr_q[DW-2:0], 1'b0} : {1'b0, sr_q[DW-1:1]};
                    cnt_d = cnt_q + CW'(1);
                end else if (hold_full) begin
                    {msb_d, sr_d} = hold_word;
                    cnt_d         = '0;
                end else if (accept) begin
                    sr_d  = i_data;
                    msb_d = i_msb_first;
                    cnt_d = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            msb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            msb_q   <= msb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_seq     = (state_q == S_SHIFT) && (msb_q ? sr_q[DW-1] : sr_q[0]);
    assign o_seq_vld = (state_q == S_SHIFT);
    assign o_busy    = (state_q == S_SHIFT) || hold_full;
    assign o_state   = state_q;

endmodule
